// File: rtl/id_scoreboard_if.sv
// Issue/writeback/status bundle between the decoder, the id_scoreboard and EX.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both 1.
interface id_scoreboard_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 3
);
    localparam int NREG = 1 << REG_W;

    logic             id_valid;
    logic             id_ready;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [REG_W-1:0] id_rd;
    logic             id_rd_we;
    logic             ex_valid;
    logic             ex_ready;
    logic             wb_valid;
    logic [REG_W-1:0] wb_rd;
    logic             flush;
    logic [NREG-1:0]  busy_mask;
    logic [CNT_W-1:0] pend_cnt;
    logic             wb_err;
    logic             dbg_state;   // 0 = RUN, 1 = DRAIN

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_rd_we,
        output ex_ready, wb_valid, wb_rd, flush,
        input  id_ready, ex_valid, busy_mask, pend_cnt, wb_err, dbg_state
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_rd_we,
        input  ex_ready, wb_valid, wb_rd, flush,
        output id_ready, ex_valid, busy_mask, pend_cnt, wb_err, dbg_state
    );
endinterface

// File: rtl/id_scoreboard.sv
// Register-hazard scoreboard between decode and EX: stalls on RAW/WAW or full pending set.
// Optional same-cycle writeback release: define SCOREBOARD_WB_BYPASS_EN.
module id_scoreboard #(
    parameter int REG_W    = 5,
    parameter int MAX_PEND = 4,
    parameter int CNT_W    = 3
) (
    input logic         clk,
    input logic         rst,
    id_scoreboard_if.slave bus
);
    localparam int NREG = 1 << REG_W;

    typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [NREG-1:0]  busy_q, busy_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             wb_err_q, wb_err_d;

    logic [NREG-1:0]  busy_view, wb_onehot, set_onehot;
    logic [CNT_W-1:0] pend_view;
    logic             wb_hit, rd_nz, hazard, full, can_issue, fire, set, clr;

    always_comb begin
        rd_nz     = bus.id_rd != '0;
        wb_hit    = bus.wb_valid & (bus.wb_rd != '0) & busy_q[bus.wb_rd];
        wb_onehot = wb_hit ? (NREG'(1) << bus.wb_rd) : '0;
`ifdef SCOREBOARD_WB_BYPASS_EN
        busy_view = busy_q & ~wb_onehot;
        pend_view = pend_q - CNT_W'(wb_hit);
`else
        busy_view = busy_q;
        pend_view = pend_q;
`endif
        // Index 0 is hardwired zero and never creates a dependency.
        hazard = (bus.id_use_rs1 & (bus.id_rs1 != '0) & busy_view[bus.id_rs1])
               | (bus.id_use_rs2 & (bus.id_rs2 != '0) & busy_view[bus.id_rs2])
               | (bus.id_rd_we   & rd_nz               & busy_view[bus.id_rd]);
        full      = (pend_view == CNT_W'(MAX_PEND)) & bus.id_rd_we & rd_nz;
        can_issue = ~hazard & ~full & (state_q == RUN) & ~bus.flush;
        fire      = bus.id_valid & bus.ex_ready & can_issue;
        set       = fire & bus.id_rd_we & rd_nz;
        clr       = wb_hit & ~bus.flush;
        set_onehot = set ? (NREG'(1) << bus.id_rd) : '0;
    end

    always_comb begin
        busy_d   = busy_q;
        pend_d   = pend_q;
        wb_err_d = 1'b0;
        state_d  = state_q;
        if (bus.flush) begin
            busy_d  = '0;
            pend_d  = '0;
            state_d = DRAIN;
        end else begin
            // Clear before set so a same-register set/clear leaves the bit set.
            busy_d   = (busy_q & ~(clr ? wb_onehot : '0)) | set_onehot;
            pend_d   = pend_q + CNT_W'(set) - CNT_W'(clr);
            wb_err_d = bus.wb_valid & (bus.wb_rd != '0) & ~busy_q[bus.wb_rd];
            case (state_q)
                RUN:     state_d = RUN;
                DRAIN:   state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RUN;
            busy_q   <= '0;
            pend_q   <= '0;
            wb_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            pend_q   <= pend_d;
            wb_err_q <= wb_err_d;
        end
    end

    // ex_valid deliberately excludes ex_ready; only id_ready looks at it.
    assign bus.ex_valid  = bus.id_valid & can_issue;
    assign bus.id_ready  = bus.ex_ready & can_issue;
    assign bus.busy_mask = busy_q;
    assign bus.pend_cnt  = pend_q;
    assign bus.wb_err    = wb_err_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_id_scoreboard.sv
// Bench for id_scoreboard: directed hazard scenarios followed by random traffic,
// all checked against a busy-register list model.
module tb_id_scoreboard;
    localparam int REG_W    = 5;
    localparam int MAX_PEND = 4;
    localparam int CNT_W    = 3;
    localparam int NREG     = 1 << REG_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_scoreboard_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    id_scoreboard #(.REG_W(REG_W), .MAX_PEND(MAX_PEND), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Model state: the list of registers awaiting writeback.
    logic [REG_W-1:0] exp_q[$];
    bit exp_err;
    bit exp_drain;
    int n_vec;
    int n_miss;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_busy(input int r);
        foreach (exp_q[i]) if (int'(exp_q[i]) == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [NREG-1:0] exp_mask();
        logic [NREG-1:0] m = '0;
        foreach (exp_q[i]) m[exp_q[i]] = 1'b1;
        return m;
    endfunction

    function automatic bit bypass_on();
`ifdef SCOREBOARD_WB_BYPASS_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // A register blocks issue if pending, unless released by this cycle's writeback under bypass.
    function automatic bit blocks(input int r, input int wbv, input int wbrd);
        if (r == 0 || !is_busy(r)) return 1'b0;
        if (bypass_on() && wbv != 0 && wbrd == r) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check_regs(input string tag);
        check({tag, ".busy_mask"}, bus.busy_mask, exp_mask());
        check({tag, ".pend_cnt"}, bus.pend_cnt, exp_q.size());
        check({tag, ".wb_err"}, bus.wb_err, exp_err);
        check({tag, ".state"}, bus.dbg_state, exp_drain);
    endtask

    task automatic drive_idle();
        bus.id_valid = 0; bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 0;
        bus.id_use_rs2 = 0; bus.id_rd = '0; bus.id_rd_we = 0; bus.ex_ready = 0;
        bus.wb_valid = 0; bus.wb_rd = '0; bus.flush = 0;
    endtask

    task automatic step(input int iv, input int rs1, input int u1, input int rs2, input int u2,
                        input int rd, input int we, input int exr, input int wbv, input int wbrd,
                        input int fl);
        int  cnt;
        bit  haz, full, ok, fire;
        @(negedge clk);
        bus.id_valid = iv[0]; bus.id_rs1 = REG_W'(rs1); bus.id_use_rs1 = u1[0];
        bus.id_rs2 = REG_W'(rs2); bus.id_use_rs2 = u2[0]; bus.id_rd = REG_W'(rd);
        bus.id_rd_we = we[0]; bus.ex_ready = exr[0]; bus.wb_valid = wbv[0];
        bus.wb_rd = REG_W'(wbrd); bus.flush = fl[0];
        #1;
        cnt = exp_q.size();
        if (bypass_on() && wbv != 0 && wbrd != 0 && is_busy(wbrd)) cnt--;
        haz  = (u1 != 0 && blocks(rs1, wbv, wbrd)) || (u2 != 0 && blocks(rs2, wbv, wbrd))
            || (we != 0 && blocks(rd, wbv, wbrd));
        full = cnt == MAX_PEND && we != 0 && rd != 0;
        ok   = !haz && !full && !exp_drain && fl == 0;
        fire = ok && iv != 0 && exr != 0;
        check("ex_valid", bus.ex_valid, iv != 0 && ok);
        check("id_ready", bus.id_ready, exr != 0 && ok);
        @(posedge clk);
        if (fl != 0) begin
            exp_q.delete();
            exp_drain = 1'b1;
            exp_err   = 1'b0;
        end else begin
            exp_drain = 1'b0;
            exp_err   = wbv != 0 && wbrd != 0 && !is_busy(wbrd);
            if (wbv != 0 && wbrd != 0)
                foreach (exp_q[i]) if (int'(exp_q[i]) == wbrd) begin exp_q.delete(i); break; end
            if (fire && we != 0 && rd != 0) exp_q.push_back(REG_W'(rd));
        end
        #1;
        check_regs("step");
    endtask

    task automatic issue(input int rd, input int we, input int rs1, input int u1);
        step(1, rs1, u1, 0, 0, rd, we, 1, 0, 0, 0);
    endtask

    task automatic wb(input int r);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, r, 0);
    endtask

    initial begin
        n_vec = 0; n_miss = 0;
        exp_err = 0; exp_drain = 0;
        drive_idle();
        rst = 1'b0;
        #1;
        check_regs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        // Asynchronous reset while rd=1,2 are pending.
        issue(1, 1, 0, 0);
        issue(2, 1, 0, 0);
        check("mask_before_rst", bus.busy_mask, 64'h6);
        @(negedge clk);
        drive_idle();
        rst = 1'b0;
        #1;
        exp_q.delete(); exp_err = 0; exp_drain = 0;
        check_regs("async_rst");
        @(negedge clk) rst = 1'b1;

        // RAW on rd=5.
        issue(5, 1, 0, 0);
        issue(6, 1, 5, 1);
        issue(6, 1, 5, 1);
        step(1, 5, 1, 0, 0, 6, 1, 1, 1, 5, 0);
        issue(6, 1, 5, 1);

        // WAW and x0 behaviour.
        issue(7, 1, 0, 0);
        issue(7, 1, 0, 0);
        issue(0, 1, 0, 0);
        step(1, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0);
        wb(6);
        wb(7);

        // Pending-set limit.
        for (int r = 1; r <= 4; r++) issue(r, 1, 0, 0);
        issue(9, 1, 0, 0);
        issue(9, 0, 0, 0);
        step(1, 0, 0, 0, 0, 9, 1, 1, 1, 2, 0);
        issue(9, 1, 0, 0);

        // Flush with an instruction presented, then DRAIN, then RUN.
        step(1, 0, 0, 0, 0, 11, 1, 1, 1, 3, 1);
        issue(11, 1, 0, 0);
        issue(11, 1, 0, 0);

        // Backpressure and writeback to an idle register.
        step(1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 10, 1, 0, 1, 12, 0);
        issue(10, 1, 0, 0);
        wb(10);

        // Random traffic concentrated on a few registers to provoke hazards.
        for (int n = 0; n < 600; n++) begin
            int wbrd;
            if (exp_q.size() != 0 && $urandom_range(0, 2) != 0)
                wbrd = int'(exp_q[$urandom_range(0, exp_q.size() - 1)]);
            else
                wbrd = $urandom_range(0, 9);
            step(($urandom_range(0, 4) != 0) ? 1 : 0,
                 $urandom_range(0, 9), $urandom_range(0, 1),
                 $urandom_range(0, 9), $urandom_range(0, 1),
                 $urandom_range(0, 9), ($urandom_range(0, 3) != 0) ? 1 : 0,
                 ($urandom_range(0, 3) != 0) ? 1 : 0,
                 $urandom_range(0, 1), wbrd,
                 ($urandom_range(0, 24) == 0) ? 1 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
